// File: rtl/km_pkg.sv
// Shared constants, FSM state encoding and width helper for the km_modred
// pseudo-Mersenne reduction stage.
package km_pkg;

  localparam int unsigned KM_W = 32;
  localparam int unsigned KM_C = 5;
  localparam longint unsigned KM_Q = (64'd1 << KM_W) - 64'(KM_C);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FOLD1 = 3'd1,
    ST_FOLD2 = 3'd2,
    ST_CORR  = 3'd3,
    ST_DONE  = 3'd4
  } km_state_e;

  // lo + C*hi with C <= 15 never exceeds W+4 bits
  function automatic int fold_width(input int w);
    return w + 4;
  endfunction

endpackage

// File: rtl/km_fold.sv
// Shared fold datapath: sum = lo + C*hi, using 2^W == C (mod Q).
module km_fold
  import km_pkg::*;
#(
  parameter int W = KM_W,
  parameter int C = KM_C
) (
  input  logic [W-1:0]             lo,
  input  logic [W-1:0]             hi,
  output logic [fold_width(W)-1:0] sum
);

  localparam int FW = fold_width(W);

  // combinational multiply-accumulate, evaluated at fold width
  always_comb begin
    sum = {4'd0, lo} + (FW'(C) * {4'd0, hi});
  end

endmodule

// File: rtl/km_modred.sv
// Reduces a 2W-bit product modulo Q = 2^W - C via two folds and one subtract.
// Optional op_count output enabled by defining KM_MODRED_OPCNT_EN.
module km_modred
  import km_pkg::*;
#(
  parameter int W = KM_W,
  parameter int C = KM_C
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_prod,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_res
`ifdef KM_MODRED_OPCNT_EN
  ,
  output logic [15:0]    op_count
`endif
);

  localparam int FW = fold_width(W);
  // Q = (2^W - 1) - (C - 1), built without a 2^W intermediate
  localparam logic [FW-1:0] Q_EXT = {4'd0, {W{1'b1}}} - FW'(C - 1);
  localparam logic [W-1:0]  Q_LO  = Q_EXT[W-1:0];

  if ((C < 1) || (C > 15)) begin : g_bad_c
    $error("km_modred: C must lie in 1..15");
  end
  if (W < 8) begin : g_bad_w
    $error("km_modred: W must be at least 8");
  end

  km_state_e        state_q, state_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     out_res_q, out_res_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [W-1:0]     fold_hi;
  logic [FW-1:0]    fold_sum;
  logic             acc_ge_q;

  // FOLD1 folds the full upper half, FOLD2 only the 4-bit carry slice
  always_comb begin
    if (state_q == ST_FOLD2) begin
      fold_hi = {{(W-4){1'b0}}, acc_q[W+3:W]};
    end else begin
      fold_hi = acc_q[2*W-1:W];
    end
  end

  km_fold #(
    .W (W),
    .C (C)
  ) u_fold (
    .lo  (acc_q[W-1:0]),
    .hi  (fold_hi),
    .sum (fold_sum)
  );

  assign acc_ge_q = (acc_q[FW-1:0] >= Q_EXT);

  // next-state and next-output logic for the reduction sequence
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    out_res_d   = out_res_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d      = in_prod;
          in_ready_d = 1'b0;
          state_d    = ST_FOLD1;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      ST_FOLD1: begin
        acc_d   = {{(2*W-FW){1'b0}}, fold_sum};
        state_d = ST_FOLD2;
      end
      ST_FOLD2: begin
        acc_d   = {{(2*W-FW){1'b0}}, fold_sum};
        state_d = ST_CORR;
      end
      ST_CORR: begin
        // acc < 2Q here, so the low W bits of acc - Q are exact
        if (acc_ge_q) begin
          out_res_d = acc_q[W-1:0] - Q_LO;
        end else begin
          out_res_d = acc_q[W-1:0];
        end
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // state, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= {(2*W){1'b0}};
      out_res_q   <= {W{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_res_q   <= out_res_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;

`ifdef KM_MODRED_OPCNT_EN
  logic [15:0] op_count_q, op_count_d;

  // wrapping count of output handshakes
  always_comb begin
    if (out_valid_q && out_ready) begin
      op_count_d = op_count_q + 16'd1;
    end else begin
      op_count_d = op_count_q;
    end
  end

  // handshake counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_q <= 16'd0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_km_modred.sv
// Directed scoreboard bench for km_modred (Q = 2^32 - 5); op_count checks
// are compiled in when KM_MODRED_OPCNT_EN is defined.
module tb_km_modred;

  localparam logic [63:0] TB_Q = 64'd4294967291;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_prod;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
`ifdef KM_MODRED_OPCNT_EN
  logic [15:0] op_count;
`endif

  int n_asserts = 0;
  int n_fail    = 0;
  logic [63:0] exp_q[$];

  km_modred dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res)
`ifdef KM_MODRED_OPCNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one product, wait (bounded) for acceptance, record the expectation
  task automatic send(input logic [63:0] p, input logic [63:0] exp);
    int k;
    k = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = p;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_prod  = {$urandom, $urandom};
    exp_q.push_back(exp);
  endtask

  task automatic receive(input string tag);
    int k;
    logic [63:0] exp;
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
    check(tag, {32'd0, out_res}, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [63:0] p;
    logic [63:0] exp;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = 64'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_res", {32'd0, out_res}, 64'd0);
    rst = 1'b0;

    // small product, plus latency from the accept edge
    send(64'd39625676, 64'd39625676);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'd4);
    receive("small");

    // boundary values
    send(64'hFFFFFFFF_FFFFFFFF, 64'd24);
    receive("all_ones");
    send(64'h00000000_FFFFFFFB, 64'd0);
    receive("eq_q");
    send(64'h00000000_FFFFFFFA, 64'd4294967290);
    receive("q_minus1");
    send(64'h00000001_00000000, 64'd5);
    receive("two_pow_w");

    // (Q-1)^2 with back-pressure and a second producer waiting
    send(64'hFFFFFFF4_00000024, 64'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
    in_valid = 1'b1;
    in_prod  = 64'h00000001_00000000;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_res", {32'd0, out_res}, exp);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hs_valid_drop", {63'd0, out_valid}, 64'd0);
    check("hs_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("second_accepted", {63'd0, in_ready}, 64'd0);
    exp_q.push_back(64'd5);
    receive("second");

    // reset during FOLD2 discards the operation
    send(64'hFFFFFFFF_FFFFFFFF, 64'd24);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    void'(exp_q.pop_back());
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) lat++;
    end
    check("midrst_no_result", 64'(lat), 64'd0);
    send(64'h00000001_00000000, 64'd5);
    receive("after_rst");

    // random products against an independent remainder model
    for (int i = 0; i < 6; i++) begin
      p = {$urandom, $urandom};
      send(p, p % TB_Q);
      receive("random");
    end

`ifdef KM_MODRED_OPCNT_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("cnt_rst", {48'd0, op_count}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      send(64'd1000 + 64'(i), 64'd1000 + 64'(i));
      receive("cnt_op");
    end
    check("cnt_three", {48'd0, op_count}, 64'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("cnt_cleared", {48'd0, op_count}, 64'd0);
    force dut.op_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.op_count_q;
    @(negedge clk);
    check("cnt_preset", {48'd0, op_count}, 64'hFFFF);
    send(64'd7, 64'd7);
    receive("cnt_wrap_op");
    check("cnt_wrap", {48'd0, op_count}, 64'd0);
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
